// File: rtl/adc_deser_pkg.sv
// Shared types and constants for the multi-lane LVDS ADC frame deserializer.
// Holds the alignment state encoding and the frame-clock pattern builder.
package adc_deser_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } deser_state_t;

    // Upper half of the word is ones, lower half zeros (12 bits -> 12'hFC0).
    function automatic logic [63:0] fco_pattern(input int w);
        logic [63:0] p;
        p = '0;
        for (int i = 0; i < w; i++) begin
            if (i >= w / 2) p[i] = 1'b1;
        end
        return p;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bank for asynchronous LVDS-side levels.
// All bits share one clock and a synchronous active-high reset.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;

    // Two metastability stages.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end

    assign o_q = r_s2;

endmodule

// File: rtl/adc_lvds_frame_deser.sv
// Multi-lane ADC serial deserializer aligned to the FCO frame clock.
// Locks after repeated good frames, outputs all lanes with a valid pulse.
module adc_lvds_frame_deser
    import adc_deser_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int DATA_WIDTH  = 12,
    parameter int LOCK_FRAMES = 4,
    parameter int UNLOCK_ERRS = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [NUM_CH-1:0]            i_din,
    input  logic                         i_fco,
    input  logic                         i_dco,
    input  logic                         i_err_cnt_clr,
    output logic [NUM_CH*DATA_WIDTH-1:0] o_des_data,
    output logic                         o_des_valid,
    output logic                         o_locked,
    output logic [CNT_WIDTH-1:0]         o_frame_err_cnt
);

    localparam int W   = DATA_WIDTH;
    localparam int BCW = $clog2(W);
    localparam int GCW = $clog2(LOCK_FRAMES + 1);
    localparam int UCW = $clog2(UNLOCK_ERRS + 1);
    localparam logic [W-1:0] FCO_PAT = W'(fco_pattern(W));

    if ((DATA_WIDTH % 2) != 0) begin : g_bad_width
        $error("DATA_WIDTH must be even");
    end

    logic [NUM_CH+1:0]   w_sync;
    logic                w_dco_s2;
    logic                w_fco_s2;
    logic [NUM_CH-1:0]   w_din_s2;
    logic                r_dco_s3;
    logic                w_bit_stb;
    logic [NUM_CH*W-1:0] r_ch_sr;
    logic [NUM_CH*W-1:0] w_ch_next;
    logic [W-1:0]        r_fco_sr;
    logic [W-1:0]        w_fco_next;
    logic                w_match;
    logic                w_frame_end;
    logic [BCW-1:0]      r_bit_cnt;
    logic [GCW-1:0]      r_good_cnt;
    logic [UCW-1:0]      r_bad_cnt;
    deser_state_t        r_state;
    deser_state_t        w_state_next;
    logic                w_out_fire;
    logic                w_bad_fire;
    logic                w_locked_next;

    sync_2ff #(
        .WIDTH(NUM_CH + 2)
    ) u_sync (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_d  ({i_dco, i_fco, i_din}),
        .o_q  (w_sync)
    );

    assign w_dco_s2    = w_sync[NUM_CH+1];
    assign w_fco_s2    = w_sync[NUM_CH];
    assign w_din_s2    = w_sync[NUM_CH-1:0];
    assign w_bit_stb   = w_dco_s2 ^ r_dco_s3;
    assign w_fco_next  = {r_fco_sr[W-2:0], w_fco_s2};
    assign w_match     = (w_fco_next == FCO_PAT);
    assign w_frame_end = (r_bit_cnt == BCW'(W - 1));

    // Post-shift view of every lane's shift register.
    always_comb begin
        w_ch_next = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_ch_next[i*W +: W] = {r_ch_sr[i*W +: W-1], w_din_s2[i]};
        end
    end

    // Alignment state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= SEARCH;
        else       r_state <= w_state_next;
    end

    // Next alignment state, evaluated only on a bit strobe.
    always_comb begin
        w_state_next = r_state;
        if (w_bit_stb) begin
            unique case (r_state)
                SEARCH: begin
                    if (w_match)
                        w_state_next = (LOCK_FRAMES == 1) ? LOCKED : CHECK;
                end
                CHECK: begin
                    if (w_frame_end) begin
                        if (!w_match)
                            w_state_next = SEARCH;
                        else if (r_good_cnt == GCW'(LOCK_FRAMES - 1))
                            w_state_next = LOCKED;
                    end
                end
                LOCKED: begin
                    if (w_frame_end && !w_match &&
                        r_bad_cnt == UCW'(UNLOCK_ERRS - 1))
                        w_state_next = SEARCH;
                end
                default: w_state_next = SEARCH;
            endcase
        end
    end

    // Frame events decoded from the current state and strobe.
    always_comb begin
        w_out_fire    = w_bit_stb && (r_state == LOCKED) &&
                        w_frame_end && w_match;
        w_bad_fire    = w_bit_stb && (r_state == LOCKED) &&
                        w_frame_end && !w_match;
        w_locked_next = (w_state_next == LOCKED);
    end

    // Shift registers, bit position and good/bad frame counters.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_dco_s3   <= 1'b0;
            r_ch_sr    <= '0;
            r_fco_sr   <= '0;
            r_bit_cnt  <= '0;
            r_good_cnt <= '0;
            r_bad_cnt  <= '0;
        end else begin
            r_dco_s3 <= w_dco_s2;
            if (w_bit_stb) begin
                r_ch_sr  <= w_ch_next;
                r_fco_sr <= w_fco_next;
                if ((r_state == SEARCH && w_match) || w_frame_end)
                    r_bit_cnt <= '0;
                else
                    r_bit_cnt <= r_bit_cnt + BCW'(1);
            end
            if (w_state_next == SEARCH)
                r_good_cnt <= '0;
            else if (w_bit_stb && r_state == SEARCH && w_match)
                r_good_cnt <= GCW'(1);
            else if (w_bit_stb && r_state == CHECK && w_frame_end)
                r_good_cnt <= r_good_cnt + GCW'(1);
            if (w_state_next != LOCKED)
                r_bad_cnt <= '0;
            else if (w_bad_fire)
                r_bad_cnt <= r_bad_cnt + UCW'(1);
            else if (w_out_fire)
                r_bad_cnt <= '0;
        end
    end

    // Registered outputs: data, valid pulse, lock flag, error count.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_des_data      <= '0;
            o_des_valid     <= 1'b0;
            o_locked        <= 1'b0;
            o_frame_err_cnt <= '0;
        end else begin
            o_des_valid <= w_out_fire;
            o_locked    <= w_locked_next;
            if (w_out_fire)
                o_des_data <= w_ch_next;
            if (i_err_cnt_clr)
                o_frame_err_cnt <= '0;
            else if (w_bad_fire && o_frame_err_cnt != '1)
                o_frame_err_cnt <= o_frame_err_cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_adc_lvds_frame_deser.sv
// Randomized self-checking bench for adc_lvds_frame_deser.
// A frame-level model predicts lock, valid pulses, data and error counts.
module tb_adc_lvds_frame_deser;

    localparam int NUM_CH  = 4;
    localparam int W       = 12;
    localparam int LF      = 4;
    localparam int UE      = 2;
    localparam int CW      = 16;
    localparam int CWS     = 3;
    localparam int BIT_CLK = 4;
    localparam int LAT     = 4;
    localparam logic [W-1:0] FCO_PAT = 12'hFC0;
    localparam logic [W-1:0] FCO_BAD = 12'hF81;

    logic                 clk;
    logic                 rst;
    logic [NUM_CH-1:0]    din;
    logic                 fco;
    logic                 dco;
    logic                 clr;
    logic [NUM_CH*W-1:0]  des_data;
    logic                 des_valid;
    logic                 locked;
    logic [CW-1:0]        err_cnt;
    logic [NUM_CH*W-1:0]  s_des_data;
    logic                 s_des_valid;
    logic                 s_locked;
    logic [CWS-1:0]       s_err_cnt;

    adc_lvds_frame_deser #(
        .NUM_CH(NUM_CH), .DATA_WIDTH(W), .LOCK_FRAMES(LF),
        .UNLOCK_ERRS(UE), .CNT_WIDTH(CW)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_din(din), .i_fco(fco),
        .i_dco(dco), .i_err_cnt_clr(clr),
        .o_des_data(des_data), .o_des_valid(des_valid),
        .o_locked(locked), .o_frame_err_cnt(err_cnt)
    );

    adc_lvds_frame_deser #(
        .NUM_CH(NUM_CH), .DATA_WIDTH(W), .LOCK_FRAMES(LF),
        .UNLOCK_ERRS(UE), .CNT_WIDTH(CWS)
    ) dut_sat (
        .i_clk(clk), .i_rst(rst), .i_din(din), .i_fco(fco),
        .i_dco(dco), .i_err_cnt_clr(clr),
        .o_des_data(s_des_data), .o_des_valid(s_des_valid),
        .o_locked(s_locked), .o_frame_err_cnt(s_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [NUM_CH*W-1:0] got_q[$];
    always @(negedge clk) begin
        if (des_valid === 1'b1) got_q.push_back(des_data);
    end

    int n_total = 0;
    int n_bad   = 0;

    bit                  m_locked;
    int                  m_good;
    int                  m_bad;
    int                  m_err;
    int                  m_err_s;
    logic [NUM_CH*W-1:0] m_last;

    bit                  f_exp;
    int                  f_nval;
    logic [NUM_CH*W-1:0] f_got;
    int                  f_lat;

    task automatic model_reset();
        m_locked = 0;
        m_good   = 0;
        m_bad    = 0;
        m_err    = 0;
        m_err_s  = 0;
        m_last   = '0;
    endtask

    task automatic rand_data(output logic [NUM_CH*W-1:0] r);
        r[31:0]  = $urandom();
        r[47:32] = 16'($urandom());
    endtask

    // One DCO transition carrying one bit; clr pulses on the strobe cycle.
    task automatic send_bit(input logic [NUM_CH-1:0] d, input logic f,
                            input bit pulse_clr, output int lat);
        din = d;
        fco = f;
        dco = ~dco;
        lat = 0;
        for (int k = 1; k <= BIT_CLK; k++) begin
            @(posedge clk);
            #1;
            if (pulse_clr && k == 2) clr = 1'b1;
            if (k == 3) clr = 1'b0;
            if (des_valid === 1'b1 && lat == 0) lat = k + 1;
        end
    endtask

    task automatic send_frame(input logic [W-1:0] fpat,
                              input logic [NUM_CH*W-1:0] data,
                              input bit do_clr);
        int l;
        got_q.delete();
        f_lat = 0;
        for (int b = W - 1; b >= 0; b--) begin
            logic [NUM_CH-1:0] d;
            for (int c = 0; c < NUM_CH; c++) d[c] = data[c*W+b];
            send_bit(d, fpat[b], do_clr && (b == 0), l);
            if (b == 0) f_lat = l;
        end
        f_nval = got_q.size();
        f_got  = (f_nval > 0) ? got_q[0] : '0;
        f_exp  = 0;
        if (!m_locked) begin
            if (fpat == FCO_PAT) begin
                m_good++;
                if (m_good == LF) begin
                    m_locked = 1;
                    m_bad    = 0;
                end
            end else begin
                m_good = 0;
            end
        end else if (fpat == FCO_PAT) begin
            m_bad  = 0;
            f_exp  = 1;
            m_last = data;
        end else begin
            m_bad++;
            if (m_err < 65535) m_err++;
            if (m_err_s < 7) m_err_s++;
            if (m_bad == UE) begin
                m_locked = 0;
                m_good   = 0;
                m_bad    = 0;
            end
        end
        if (do_clr) begin
            m_err   = 0;
            m_err_s = 0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; din = '0; fco = 1'b0; dco = 1'b0; clr = 1'b0;
        @(posedge clk);
        #1;
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if (des_valid !== 1'b0 || locked !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_flags: valid=%b locked=%b want 0 0",
                     des_valid, locked);
        end
        n_total++;
        if (des_data !== '0 || err_cnt !== '0) begin
            n_bad++;
            $display("FAIL reset_data: data=%h err=%h want 0 0",
                     des_data, err_cnt);
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_aligned();
        logic [NUM_CH*W-1:0] d;
        for (int i = 0; i < NUM_CH; i++) d[i*W +: W] = 12'h555 + W'(i);
        for (int f = 1; f <= 5; f++) begin
            send_frame(FCO_PAT, d, 0);
            n_total++;
            if (locked !== m_locked || f_nval != int'(f_exp)) begin
                n_bad++;
                $display("FAIL aligned_f%0d: locked=%b nval=%0d want %b %0d",
                         f, locked, f_nval, m_locked, f_exp);
            end
        end
        n_total++;
        if (f_got !== m_last || err_cnt !== CW'(m_err)) begin
            n_bad++;
            $display("FAIL aligned_data: data=%h err=%0d want %h %0d",
                     f_got, err_cnt, m_last, m_err);
        end
    endtask

    task automatic test_back_to_back();
        logic [NUM_CH*W-1:0] d[2];
        d[0] = '1;
        d[1] = '0;
        for (int f = 0; f < 2; f++) begin
            send_frame(FCO_PAT, d[f], 0);
            n_total++;
            if (f_nval != 1 || f_got !== d[f] || f_lat != LAT) begin
                n_bad++;
                $display("FAIL b2b_%0d: nval=%0d data=%h lat=%0d want 1 %h %0d",
                         f, f_nval, f_got, f_lat, d[f], LAT);
            end
        end
    endtask

    task automatic test_single_bad();
        logic [NUM_CH*W-1:0] d;
        rand_data(d);
        send_frame(FCO_BAD, d, 0);
        n_total++;
        if (f_nval != 0 || des_data !== m_last || locked !== 1'b1 ||
            err_cnt !== CW'(m_err)) begin
            n_bad++;
            $display("FAIL single_bad: nval=%0d data=%h lk=%b err=%0d want 0 %h 1 %0d",
                     f_nval, des_data, locked, err_cnt, m_last, m_err);
        end
        for (int f = 0; f < 2; f++) begin
            rand_data(d);
            send_frame(FCO_PAT, d, 0);
            n_total++;
            if (f_nval != 1 || f_got !== d || f_lat != LAT) begin
                n_bad++;
                $display("FAIL after_bad_%0d: nval=%0d data=%h lat=%0d want 1 %h %0d",
                         f, f_nval, f_got, f_lat, d, LAT);
            end
        end
    endtask

    task automatic test_unlock_realign();
        logic [NUM_CH*W-1:0] d;
        int l;
        for (int f = 0; f < 2; f++) begin
            rand_data(d);
            send_frame(FCO_BAD, d, 0);
            n_total++;
            if (locked !== m_locked || f_nval != 0 ||
                err_cnt !== CW'(m_err)) begin
                n_bad++;
                $display("FAIL unlock_%0d: lk=%b nval=%0d err=%0d want %b 0 %0d",
                         f, locked, f_nval, err_cnt, m_locked, m_err);
            end
        end
        for (int b = 0; b < 3; b++)
            send_bit(NUM_CH'($urandom()), 1'b0, 0, l);
        for (int f = 1; f <= 6; f++) begin
            rand_data(d);
            send_frame(FCO_PAT, d, 0);
            n_total++;
            if (locked !== m_locked || f_nval != int'(f_exp) ||
                (f_exp && f_got !== d)) begin
                n_bad++;
                $display("FAIL realign_f%0d: lk=%b nval=%0d data=%h want %b %0d %h",
                         f, locked, f_nval, f_got, m_locked, f_exp, d);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [NUM_CH*W-1:0] d;
        int l;
        for (int b = W - 1; b >= W - 5; b--)
            send_bit(NUM_CH'($urandom()), FCO_PAT[b], 0, l);
        rst = 1'b1; din = '0; fco = 1'b0; dco = 1'b0;
        @(posedge clk);
        #1;
        n_total++;
        if (des_valid !== 1'b0 || locked !== 1'b0 ||
            des_data !== '0 || err_cnt !== '0) begin
            n_bad++;
            $display("FAIL mid_reset: v=%b lk=%b data=%h err=%0d want all 0",
                     des_valid, locked, des_data, err_cnt);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int f = 1; f <= 5; f++) begin
            rand_data(d);
            send_frame(FCO_PAT, d, 0);
            n_total++;
            if (locked !== m_locked || f_nval != int'(f_exp) ||
                (f_exp && f_got !== d)) begin
                n_bad++;
                $display("FAIL relock_f%0d: lk=%b nval=%0d data=%h want %b %0d %h",
                         f, locked, f_nval, f_got, m_locked, f_exp, d);
            end
        end
    endtask

    task automatic test_err_clr_sat();
        logic [NUM_CH*W-1:0] d;
        rand_data(d);
        send_frame(FCO_BAD, d, 1);
        n_total++;
        if (err_cnt !== CW'(m_err) || s_err_cnt !== CWS'(m_err_s) ||
            locked !== m_locked) begin
            n_bad++;
            $display("FAIL clr_vs_inc: err=%0d serr=%0d lk=%b want %0d %0d %b",
                     err_cnt, s_err_cnt, locked, m_err, m_err_s, m_locked);
        end
        rand_data(d);
        send_frame(FCO_PAT, d, 0);
        for (int i = 0; i < 10; i++) begin
            rand_data(d);
            send_frame(FCO_BAD, d, 0);
            rand_data(d);
            send_frame(FCO_PAT, d, 0);
        end
        n_total++;
        if (err_cnt !== CW'(m_err) || locked !== m_locked) begin
            n_bad++;
            $display("FAIL err_count: err=%0d lk=%b want %0d %b",
                     err_cnt, locked, m_err, m_locked);
        end
        n_total++;
        if (s_err_cnt !== CWS'(m_err_s)) begin
            n_bad++;
            $display("FAIL err_saturate: serr=%0d want %0d",
                     s_err_cnt, m_err_s);
        end
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_back_to_back();
        test_single_bad();
        test_unlock_realign();
        test_reset_mid();
        test_err_clr_sat();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
